// File: rtl/timer_irq_if.sv
// rtl/timer_irq_if.sv - single-cycle request / one-cycle acknowledge data-bus port
interface timer_irq_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, data_i,
    input  data_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, data_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped machine timer with prescaler, auto-reload compare and sticky interrupt
module timer_irq #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  timer_irq_if.slave bus,
  output logic       irq_o
);

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_COUNT = 2'd1;
  localparam logic [1:0] ADDR_CMP   = 2'd2;
  localparam logic [1:0] ADDR_PRESC = 2'd3;

  logic                   en_q, en_d;
  logic                   ie_q, ie_d;
  logic                   pend_q, pend_d;
  logic [31:0]            count_q, count_d;
  logic [31:0]            cmp_q, cmp_d;
  logic [PRESC_WIDTH-1:0] presc_q, presc_d;
  logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;

  logic       wr_en;
  logic       rd_en;
  logic [1:0] sel;
  logic       tick;
  logic       match;

  // Only addr[3:2] selects a register; the rest is decoded by the interconnect.
  logic unused_addr;
  assign unused_addr = ^{bus.addr_i[31:4], bus.addr_i[1:0]};

  // Next-state logic: prescaler, counter, pending flag, register writes and read mux.
  always_comb begin
    sel   = bus.addr_i[3:2];
    wr_en = bus.req_i & bus.we_i;
    rd_en = bus.req_i & ~bus.we_i;
    // Tick and match use pre-write state so same-cycle writes only affect later ticks.
    tick  = en_q && (pcnt_q == presc_q);
    match = (count_q == cmp_q);

    en_d    = en_q;
    ie_d    = ie_q;
    pend_d  = pend_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    presc_d = presc_q;
    pcnt_d  = pcnt_q;

    if (!en_q || tick) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 1'b1;
    end

    if (tick) begin
      count_d = match ? 32'd0 : count_q + 32'd1;
    end

    if (wr_en) begin
      case (sel)
        ADDR_CTRL: begin
          en_d = bus.data_i[0];
          ie_d = bus.data_i[1];
          if (bus.data_i[2]) pend_d = 1'b0;
          // Keep the prescaler at 0 from the moment counting is disabled.
          if (!bus.data_i[0]) pcnt_d = '0;
        end
        ADDR_COUNT: begin
          count_d = bus.data_i;
          pcnt_d  = '0;
        end
        ADDR_CMP: begin
          cmp_d = bus.data_i;
        end
        default: begin
          presc_d = bus.data_i[PRESC_WIDTH-1:0];
          pcnt_d  = '0;
        end
      endcase
    end

    // A match sets pending even if software clears it in the same cycle.
    if (tick && match) pend_d = 1'b1;

    ack_d   = bus.req_i;
    rdata_d = 32'd0;
    if (rd_en) begin
      case (sel)
        ADDR_CTRL:  rdata_d = {29'd0, pend_q, ie_q, en_q};
        ADDR_COUNT: rdata_d = count_q;
        ADDR_CMP:   rdata_d = cmp_q;
        default:    rdata_d = 32'(presc_q);
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      pend_q  <= 1'b0;
      count_q <= 32'd0;
      cmp_q   <= 32'hFFFF_FFFF;
      presc_q <= '0;
      pcnt_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;
  assign irq_o      = pend_q & ie_q;

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - scoreboard bench for timer_irq
module tb_timer_irq;

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_COUNT = 2'd1;
  localparam logic [1:0] A_CMP   = 2'd2;
  localparam logic [1:0] A_PRESC = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq_o;

  timer_irq_if bus_if();

  timer_irq #(.PRESC_WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  int reqs  = 0;

  bit          q_rd[$];
  logic [31:0] q_exp[$];
  string       q_name[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one scoreboard entry per acknowledge, compare read data.
  always @(negedge clk) begin : monitor
    bit          r;
    logic [31:0] e;
    string       n;
    if (bus_if.ack_o === 1'b1) begin
      acks++;
      if (q_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected: got ack with empty scoreboard, expected none");
      end else begin
        r = q_rd.pop_front();
        e = q_exp.pop_front();
        n = q_name.pop_front();
        if (r) chk(n, bus_if.data_o, e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cyc(input bit we, input logic [1:0] a, input logic [31:0] d);
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = we;
    bus_if.addr_i = {28'h0, a, 2'b00};
    bus_if.data_i = d;
    reqs++;
    @(posedge clk);
    #1;
    bus_if.req_i  = 1'b0;
    bus_if.we_i   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    q_rd.push_back(1'b0);
    q_exp.push_back(32'd0);
    q_name.push_back("write");
    cyc(1'b1, a, d);
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    q_rd.push_back(1'b1);
    q_exp.push_back(exp);
    q_name.push_back(name);
    cyc(1'b0, a, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  logic [31:0] b_wdata [8] = '{32'h2, 32'h1234_5678, 32'hA5A5_A5A5, 32'hFFFF_1234,
                                32'h6, 32'hDEAD_BEEF, 32'h0, 32'h0000_ABCD};
  logic [31:0] b_rexp  [8] = '{32'h2, 32'h1234_5678, 32'hA5A5_A5A5, 32'h0000_1234,
                                32'h2, 32'hDEAD_BEEF, 32'h0, 32'h0000_ABCD};

  initial begin
    int acks0;
    bus_if.req_i  = 1'b0;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = 32'd0;
    bus_if.data_i = 32'd0;
    idle(3);
    rst = 1'b0;

    // Reset values
    rd("rst_ctrl",  A_CTRL,  32'h0);
    rd("rst_count", A_COUNT, 32'h0);
    rd("rst_cmp",   A_CMP,   32'hFFFF_FFFF);
    rd("rst_presc", A_PRESC, 32'h0);
    idle(1);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("ack_single_cycle", 32'(bus_if.ack_o), 32'd0);
    chk("rst_acks", acks, reqs);

    // Periodic interrupt: PRESC=1, CMP=3 -> period 8
    do_reset();
    wr(A_PRESC, 32'd1);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h3);
    idle(7);
    chk("irq_before_match", 32'(irq_o), 32'd0);
    idle(1);
    chk("irq_at_match", 32'(irq_o), 32'd1);
    rd("count_after_match", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    chk("irq_after_w1c", 32'(irq_o), 32'd0);
    idle(5);
    chk("irq_before_2nd", 32'(irq_o), 32'd0);
    idle(1);
    chk("irq_2nd_match", 32'(irq_o), 32'd1);

    // Wrap-around, IE gating, EN freeze
    do_reset();
    wr(A_CMP, 32'd2);
    wr(A_COUNT, 32'hFFFF_FFFE);
    wr(A_PRESC, 32'd0);
    wr(A_CTRL, 32'h1);
    rd("wrap_c0", A_COUNT, 32'hFFFF_FFFE);
    rd("wrap_c1", A_COUNT, 32'hFFFF_FFFF);
    rd("wrap_c2", A_COUNT, 32'h0);
    rd("wrap_c3", A_COUNT, 32'h1);
    rd("wrap_no_pend", A_CTRL, 32'h1);
    rd("wrap_pend", A_CTRL, 32'h5);
    chk("irq_gated", 32'(irq_o), 32'd0);
    wr(A_CTRL, 32'h3);
    chk("irq_ie_set", 32'(irq_o), 32'd1);
    wr(A_CTRL, 32'h2);
    chk("irq_hold_en0", 32'(irq_o), 32'd1);
    rd("freeze_a", A_COUNT, 32'h0);
    idle(20);
    rd("freeze_b", A_COUNT, 32'h0);

    // Collision: COUNT write on a tick, and prescaler restart
    do_reset();
    wr(A_PRESC, 32'd3);
    wr(A_CMP, 32'd100);
    wr(A_CTRL, 32'h1);
    idle(7);
    wr(A_COUNT, 32'h10);
    rd("coll_wr_wins", A_COUNT, 32'h10);
    idle(2);
    rd("coll_hold", A_COUNT, 32'h10);
    rd("coll_tick", A_COUNT, 32'h11);
    wr(A_COUNT, 32'h20);
    idle(2);
    rd("presc_restart_a", A_COUNT, 32'h20);
    rd("presc_restart_b", A_COUNT, 32'h20);
    rd("presc_restart_c", A_COUNT, 32'h21);

    // Collision: PEND clear on a match cycle
    do_reset();
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h1);
    idle(3);
    wr(A_CTRL, 32'h5);
    rd("w1c_on_match", A_CTRL, 32'h5);
    wr(A_CTRL, 32'h4);
    rd("w1c_clear", A_CTRL, 32'h0);

    // Bus stress then reset mid-burst
    do_reset();
    idle(1);
    acks0 = acks;
    for (int i = 0; i < 8; i++) begin
      wr(2'(i % 4), b_wdata[i]);
      rd("burst_rd", 2'(i % 4), b_rexp[i]);
    end
    wr(A_CMP, 32'h77);
    bus_if.req_i  = 1'b1;
    bus_if.we_i   = 1'b0;
    bus_if.addr_i = {28'h0, A_COUNT, 2'b00};
    rst = 1'b1;
    @(posedge clk);
    #1;
    bus_if.req_i = 1'b0;
    @(negedge clk);
    chk("ack_dropped_rst", 32'(bus_if.ack_o), 32'd0);
    chk("burst_acks", acks - acks0, 17);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rd("rst2_ctrl",  A_CTRL,  32'h0);
    rd("rst2_count", A_COUNT, 32'h0);
    rd("rst2_cmp",   A_CMP,   32'hFFFF_FFFF);
    rd("rst2_presc", A_PRESC, 32'h0);

    idle(2);
    chk("ack_total", acks, reqs);
    chk("scoreboard_empty", q_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
